// File: rtl/reduce8_pkg.sv
// ============================================================================
// Module      : reduce8_pkg
// Description : Shared types and constants for the reduce8 arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reduce8_pkg;

  localparam int REDUCE_W = 8;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } reduce_op_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/reduce8.sv
// ============================================================================
// Module      : reduce8
// Description : Combinational 8-bit AND/OR/NAND reduction; the XOR (parity)
//               leg exists only when REDUCE8_XOR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduce8
  import reduce8_pkg::*;
(
  input  logic [REDUCE_W-1:0] a,
  input  logic [1:0]          op,
  output logic                y,
  output logic                err
);

  always_comb begin
    y   = 1'b0;
    err = 1'b0;
    case (reduce_op_t'(op))
      OP_AND:  y = &a;
      OP_OR:   y = |a;
      OP_NAND: y = ~(&a);
      OP_XOR: begin
`ifdef REDUCE8_XOR_EN
        y = ^a;
`else
        // Unsupported in this build: flag it and keep y at 0.
        err = 1'b1;
`endif
      end
      default: begin
        y   = 1'b0;
        err = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reduce8_arbiter.sv
// ============================================================================
// Module      : reduce8_arbiter
// Description : Round-robin arbiter sharing one reduce8 unit between NREQ
//               requesters; registered, id-tagged result. XOR op is enabled
//               by the REDUCE8_XOR_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduce8_arbiter
  import reduce8_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*8-1:0]      req_data,
  input  logic [NREQ*2-1:0]      req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_y,
  output logic [IDW-1:0]         rsp_id,
  output logic [REDUCE_W-1:0]    rsp_data,
  output logic                   rsp_err
);

  localparam logic [0:0] ST_IDLE = ARB_IDLE;
  localparam logic [0:0] ST_HOLD = ARB_HOLD;

  logic [0:0]          r_state;
  logic [IDW-1:0]      r_ptr;
  logic                r_y;
  logic [IDW-1:0]      r_id;
  logic [REDUCE_W-1:0] r_data;
  logic                r_err;

  logic                w_can_accept;
  logic                w_found;
  logic [IDW-1:0]      w_win;
  logic [IDW:0]        w_scan;
  logic [IDW-1:0]      w_cand;
  logic                w_xfer;
  logic [REDUCE_W-1:0] w_sel_data;
  logic [1:0]          w_sel_op;
  logic                w_y;
  logic                w_err;

  // Gating with reset_n keeps grants low for the whole reset assertion.
  assign w_can_accept = reset_n && ((r_state == ST_IDLE) || rsp_ready);

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_scan >= (IDW+1)'(NREQ)) begin
        w_scan = w_scan - (IDW+1)'(NREQ);
      end
      w_cand = w_scan[IDW-1:0];
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_xfer    = w_can_accept && w_found;
  assign req_ready = w_xfer ? (NREQ'(1) << w_win) : '0;

  assign w_sel_data = req_data[w_win*REDUCE_W +: REDUCE_W];
  assign w_sel_op   = req_op[w_win*2 +: 2];

  reduce8 u_reduce8 (
    .a   (w_sel_data),
    .op  (w_sel_op),
    .y   (w_y),
    .err (w_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_y     <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (w_xfer) begin
      r_state <= ST_HOLD;
      r_ptr   <= (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
      r_y     <= w_y & ~w_err;
      r_id    <= w_win;
      r_data  <= w_sel_data;
      r_err   <= w_err;
    end else if ((r_state == ST_HOLD) && rsp_ready) begin
      r_state <= ST_IDLE;
    end
  end

  assign rsp_valid = (r_state == ST_HOLD);
  assign rsp_y     = r_y;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

endmodule

`default_nettype wire

// File: doc/reduce8_arbiter.md
# reduce8_arbiter

Round-robin arbiter and sequencer that shares one 8-bit reduction unit (AND/OR/optional XOR over all eight bits) between `NREQ` requesters. Each requester presents a byte and an opcode with a valid/ready handshake. The arbiter grants one requester per accepted cycle and drives the shared reduction datapath. It returns a registered one-bit result tagged with the requester index. It sits between the client blocks and the single `reduce8` datapath instance, so those clients never instantiate their own reduction gates.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; legal 2..8, need not be a power of two.
- `IDW`, `$clog2(NREQ)`, width of requester index (derived, not overridden).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  bit i: requester i has a request.
- `req_ready`  out  NREQ  one-hot grant; bit i high means requester i transfers this cycle.
- `req_data`  in  NREQ*8  flat; byte i at [8i+7:8i].
- `req_op`  in  NREQ*2  flat; op i at [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NAND.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_y`  out  1  reduction result.
- `rsp_id`  out  IDW  index of the requester served.
- `rsp_data`  out  8  echo of the operand byte.
- `rsp_err`  out  1  opcode not supported in this build.

## Operation
- States:
  - `IDLE`: no result held.
  - `HOLD`: result held, `rsp_valid`=1.
- `can_accept` = (state==IDLE) || (state==HOLD && rsp_ready).
- Arbitration: when `can_accept` holds, select the first i with `req_valid[i]`=1, scanning from `ptr` upward modulo NREQ. `req_ready` is one-hot at the winner and 0 otherwise. `req_ready`=0 for all requesters when `!can_accept`.
- On transfer:
  - Compute `reduce8` result from the winner's data and op, and register `rsp_y`/`rsp_id`/`rsp_data`/`rsp_err`.
  - `ptr` <= (winner+1) mod NREQ, wrapping to 0 after NREQ-1 for non-power-of-two NREQ.
  - state <= HOLD.
- HOLD with `rsp_ready`=1 and no valid request: state <= IDLE, `rsp_valid` drops next cycle.
- HOLD with `rsp_ready`=1 and a request: back-to-back; the new result replaces the old one and state stays HOLD.
- HOLD with `rsp_ready`=0: outputs frozen, `ptr` frozen.
- Requesters hold `req_valid`/`req_data`/`req_op` stable until granted. A request is never lost or reordered within a requester.
- NAND result = ~AND.
- `rsp_err`=1 forces `rsp_y`=0.

## Timing
- `req_ready` is combinational from `req_valid`, `ptr`, state and `rsp_ready`. No combinational path from `req_data`/`req_op`.
- Latency: transfer in cycle N; `rsp_valid`/`rsp_y` are valid from cycle N+1.
- Throughput: one result per cycle while `rsp_ready`=1.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in any NREQ consecutive transfers.
- Reset (asynchronous, any cycle including HOLD):
  - state=IDLE, `ptr`=0.
  - `rsp_valid`=0, `rsp_y`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0.
  - `req_ready`=0 while `reset_n`=0.
  - An in-flight result is discarded.
- First grant after reset release goes to the lowest valid index.

## Configuration
- `REDUCE8_XOR_EN`:
  - Defined: op 10 computes XOR-reduction (parity), `rsp_err`=0.
  - Undefined: op 10 returns `rsp_err`=1 and `rsp_y`=0; the XOR tree is not synthesized.
- Ops 00, 01 and 11 behave identically in both builds.

## Structure
- Package `reduce8_pkg`:
  - enum `reduce_op_t` (AND, OR, XOR, NAND).
  - enum `arb_state_t` (IDLE, HOLD).
  - constant `REDUCE_W`=8.
- Sub-module `reduce8`: combinational; inputs `a[7:0]`, `op`; outputs `y`, `err`. The XOR leg is guarded by `REDUCE8_XOR_EN`.
- The arbiter holds the state machine, `ptr`, grant logic and output registers.

## Test plan
- Single requester 0, data 255, op AND -> `req_ready[0]` same cycle; next cycle `rsp_valid`=1, `rsp_y`=1, `rsp_id`=0. Repeat with data 2, 5 and 0 -> `rsp_y`=0 each.
- All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,..., one per cycle, no bubbles.
- rsp_ready=0 for 3 cycles with results pending:
  - `rsp_valid`/`rsp_y`/`rsp_id` stay frozen.
  - `req_ready`=0 throughout.
  - Resuming serves the next index after the last winner.
- Requester 2 with data 0 and op OR -> `rsp_y`=0. Data 5 with op NAND -> `rsp_y`=1.
- Op XOR, data 7:
  - With `REDUCE8_XOR_EN` -> `rsp_y`=1, `rsp_err`=0.
  - Without -> `rsp_err`=1, `rsp_y`=0.
- Assert reset_n=0 while in HOLD -> all outputs 0 immediately. After release, requesters 1 and 3 valid -> requester 1 granted first.
